// File: rtl/branch_resolve.sv
// Branch resolution stage: it latches compare results into a flag register and evaluates branch
// conditions against them. It drives taken/next_pc and a fixed-length fetch flush after each taken branch.

`ifndef CMP_EQ
`define CMP_EQ 2'b00
`endif
`ifndef CMP_L
`define CMP_L 2'b01
`endif
`ifndef CMP_G
`define CMP_G 2'b10
`endif

module branch_resolve #(
    parameter int ADDR_WIDTH   = 32,
    parameter int INSTR_BYTES  = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmp_valid,
    input  logic [1:0]            CMPin,
    input  logic                  br_valid,
    output logic                  br_ready,
    input  logic [2:0]            br_cond,
    input  logic [ADDR_WIDTH-1:0] br_pc,
    input  logic [ADDR_WIDTH-1:0] br_offset,
    output logic                  resolve_valid,
    output logic                  taken,
    output logic [ADDR_WIDTH-1:0] next_pc,
    output logic                  flush,
    output logic                  flags_valid
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(INSTR_BYTES);

    typedef enum logic [2:0] {
        COND_ALWAYS = 3'b000,
        COND_EQ     = 3'b001,
        COND_NE     = 3'b010,
        COND_LT     = 3'b011,
        COND_GE     = 3'b100,
        COND_GT     = 3'b101,
        COND_LE     = 3'b110,
        COND_NEVER  = 3'b111
    } cond_e;

    typedef enum logic {IDLE, FLUSH} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [1:0]              flags_q, flags_d;
    logic                    flags_valid_q, flags_valid_d;
    logic                    resolve_valid_q, resolve_valid_d;
    logic                    taken_q, taken_d;
    logic [ADDR_WIDTH-1:0]   next_pc_q, next_pc_d;

    logic                    cmp_legal;
    logic [1:0]              eff_flags;
    logic                    flags_known;
    logic                    needs_flags;
    logic                    cond_true;
    logic                    accept;

    // A same-cycle legal compare result is forwarded ahead of the flag register.
    assign cmp_legal   = cmp_valid && (CMPin != 2'b11);
    assign eff_flags   = cmp_legal ? CMPin : flags_q;
    assign flags_known = cmp_legal || flags_valid_q;

    // NOTE: every signal driven in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        needs_flags = 1'b1;
        cond_true   = 1'b0;
        case (cond_e'(br_cond))
            COND_ALWAYS: begin cond_true = 1'b1; needs_flags = 1'b0; end
            COND_EQ:     cond_true = (eff_flags == `CMP_EQ);
            COND_NE:     cond_true = (eff_flags != `CMP_EQ);
            COND_LT:     cond_true = (eff_flags == `CMP_L);
            COND_GE:     cond_true = (eff_flags == `CMP_EQ) || (eff_flags == `CMP_G);
            COND_GT:     cond_true = (eff_flags == `CMP_G);
            COND_LE:     cond_true = (eff_flags == `CMP_EQ) || (eff_flags == `CMP_L);
            COND_NEVER:  begin cond_true = 1'b0; needs_flags = 1'b0; end
            default:     cond_true = 1'b0;
        endcase
    end

    assign br_ready = (state_q == IDLE) && (!needs_flags || flags_known);
    assign accept   = br_valid && br_ready;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        flags_d         = cmp_legal ? CMPin : flags_q;
        flags_valid_d   = flags_valid_q || cmp_legal;
        resolve_valid_d = accept;
        taken_d         = taken_q;
        next_pc_d       = next_pc_q;

        if (accept) begin
            taken_d   = cond_true;
            next_pc_d = cond_true ? (br_pc + br_offset) : (br_pc + PC_STEP);
        end

        case (state_q)
            IDLE: begin
                if (accept && cond_true) begin
                    state_d = FLUSH;
                    cnt_d   = CNT_LOAD;
                end
            end
            FLUSH: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            flags_q         <= `CMP_EQ;
            flags_valid_q   <= 1'b0;
            resolve_valid_q <= 1'b0;
            taken_q         <= 1'b0;
            next_pc_q       <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            flags_q         <= flags_d;
            flags_valid_q   <= flags_valid_d;
            resolve_valid_q <= resolve_valid_d;
            taken_q         <= taken_d;
            next_pc_q       <= next_pc_d;
        end
    end

    assign resolve_valid = resolve_valid_q;
    assign taken         = taken_q;
    assign next_pc       = next_pc_q;
    assign flags_valid   = flags_valid_q;
    assign flush         = (state_q == FLUSH);

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: a directed vector table, a reset-during-flush sequence, and random
// stimulus checked against a remaining-flush-count reference model.

module tb_branch_resolve;

    localparam logic [1:0] EQ = 2'b00;
    localparam logic [1:0] LT = 2'b01;
    localparam logic [1:0] GT = 2'b10;
    localparam int F = 2;

    logic        clk;
    logic        rst;
    logic        cmp_valid;
    logic [1:0]  CMPin;
    logic        br_valid;
    logic        br_ready;
    logic [2:0]  br_cond;
    logic [31:0] br_pc;
    logic [31:0] br_offset;
    logic        resolve_valid;
    logic        taken;
    logic [31:0] next_pc;
    logic        flush;
    logic        flags_valid;

    int checks = 0;
    int errors = 0;

    branch_resolve #(.ADDR_WIDTH(32), .INSTR_BYTES(4), .FLUSH_CYCLES(F)) dut (
        .clk(clk), .rst(rst),
        .cmp_valid(cmp_valid), .CMPin(CMPin),
        .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond),
        .br_pc(br_pc), .br_offset(br_offset),
        .resolve_valid(resolve_valid), .taken(taken), .next_pc(next_pc),
        .flush(flush), .flags_valid(flags_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = inputs driven for a cycle plus everything observable during that same cycle.
    typedef struct {
        logic        cv;
        logic [1:0]  cmp;
        logic        bv;
        logic [2:0]  cond;
        logic [31:0] pc;
        logic [31:0] off;
        logic        e_ready;
        logic        e_rv;
        logic        e_taken;
        logic [31:0] e_npc;
        logic        e_flush;
        logic        e_fv;
    } vec_t;

    vec_t tbl[19];

    // Reference model state
    logic [1:0]  m_flags;
    logic        m_fv;
    int          m_flush_left;
    logic        m_rv;
    logic        m_taken;
    logic [31:0] m_npc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cv, input logic [1:0] cmp, input logic bv,
                         input logic [2:0] cond, input logic [31:0] pc, input logic [31:0] off);
        cmp_valid = cv;
        CMPin     = cmp;
        br_valid  = bv;
        br_cond   = cond;
        br_pc     = pc;
        br_offset = off;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, EQ, 1'b0, 3'd0, 32'h0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic cond_holds(input logic [2:0] cond, input logic [1:0] f);
        case (cond)
            3'd0:    return 1'b1;
            3'd1:    return f == EQ;
            3'd2:    return f != EQ;
            3'd3:    return f == LT;
            3'd4:    return (f == EQ) || (f == GT);
            3'd5:    return f == GT;
            3'd6:    return (f == EQ) || (f == LT);
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        drive(1'b0, EQ, 1'b0, 3'd0, 32'h0, 32'h0);

        // cv cmp bv cond pc off | ready rv taken npc flush fv
        tbl[0]  = '{1'b0, EQ,    1'b1, 3'd1, 32'h10,       32'h20,  1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0};
        tbl[1]  = '{1'b1, EQ,    1'b1, 3'd1, 32'h10,       32'h20,  1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0};
        tbl[2]  = '{1'b0, EQ,    1'b0, 3'd0, 32'h0,        32'h0,   1'b0, 1'b1, 1'b1, 32'h30,  1'b1, 1'b1};
        tbl[3]  = '{1'b0, EQ,    1'b0, 3'd0, 32'h0,        32'h0,   1'b0, 1'b0, 1'b1, 32'h30,  1'b1, 1'b1};
        tbl[4]  = '{1'b1, LT,    1'b0, 3'd0, 32'h0,        32'h0,   1'b1, 1'b0, 1'b1, 32'h30,  1'b0, 1'b1};
        tbl[5]  = '{1'b0, EQ,    1'b1, 3'd4, 32'h100,      32'h40,  1'b1, 1'b0, 1'b1, 32'h30,  1'b0, 1'b1};
        tbl[6]  = '{1'b0, EQ,    1'b1, 3'd3, 32'h100,      32'h40,  1'b1, 1'b1, 1'b0, 32'h104, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, EQ,    1'b1, 3'd0, 32'h0,        32'h0,   1'b0, 1'b1, 1'b1, 32'h140, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, EQ,    1'b1, 3'd0, 32'h0,        32'h0,   1'b0, 1'b0, 1'b1, 32'h140, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, EQ,    1'b1, 3'd0, 32'hFFFFFFFC, 32'h8,   1'b1, 1'b0, 1'b1, 32'h140, 1'b0, 1'b1};
        tbl[10] = '{1'b0, EQ,    1'b0, 3'd0, 32'h0,        32'h0,   1'b0, 1'b1, 1'b1, 32'h4,   1'b1, 1'b1};
        tbl[11] = '{1'b0, EQ,    1'b0, 3'd0, 32'h0,        32'h0,   1'b0, 1'b0, 1'b1, 32'h4,   1'b1, 1'b1};
        tbl[12] = '{1'b1, GT,    1'b0, 3'd0, 32'h0,        32'h0,   1'b1, 1'b0, 1'b1, 32'h4,   1'b0, 1'b1};
        tbl[13] = '{1'b1, EQ,    1'b1, 3'd5, 32'hFFFFFFFC, 32'h10,  1'b1, 1'b0, 1'b1, 32'h4,   1'b0, 1'b1};
        tbl[14] = '{1'b0, EQ,    1'b1, 3'd1, 32'h200,      32'h8,   1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1};
        tbl[15] = '{1'b1, 2'b11, 1'b0, 3'd0, 32'h0,        32'h0,   1'b0, 1'b1, 1'b1, 32'h208, 1'b1, 1'b1};
        tbl[16] = '{1'b0, EQ,    1'b0, 3'd0, 32'h0,        32'h0,   1'b0, 1'b0, 1'b1, 32'h208, 1'b1, 1'b1};
        tbl[17] = '{1'b0, EQ,    1'b1, 3'd2, 32'h300,      32'h10,  1'b1, 1'b0, 1'b1, 32'h208, 1'b0, 1'b1};
        tbl[18] = '{1'b0, EQ,    1'b0, 3'd0, 32'h0,        32'h0,   1'b1, 1'b1, 1'b0, 32'h304, 1'b0, 1'b1};

        // Reset state
        #2;
        check("rst_flush", flush, 1'b0);
        check("rst_rv", resolve_valid, 1'b0);
        check("rst_fv", flags_valid, 1'b0);
        check("rst_npc", next_pc, 32'h0);
        do_reset();

        // Directed vectors
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].cv, tbl[i].cmp, tbl[i].bv, tbl[i].cond, tbl[i].pc, tbl[i].off);
            #1;
            check($sformatf("vec%0d_ready", i), br_ready, tbl[i].e_ready);
            check($sformatf("vec%0d_rv", i), resolve_valid, tbl[i].e_rv);
            check($sformatf("vec%0d_taken", i), taken, tbl[i].e_taken);
            check($sformatf("vec%0d_npc", i), next_pc, tbl[i].e_npc);
            check($sformatf("vec%0d_flush", i), flush, tbl[i].e_flush);
            check($sformatf("vec%0d_fv", i), flags_valid, tbl[i].e_fv);
            tick();
        end

        // NEVER before any compare, then reset during the first flush cycle
        do_reset();
        drive(1'b0, EQ, 1'b1, 3'd7, 32'h40, 32'h100);
        #1;
        check("never_ready", br_ready, 1'b1);
        check("never_fv", flags_valid, 1'b0);
        tick();
        drive(1'b0, EQ, 1'b0, 3'd0, 32'h0, 32'h0);
        #1;
        check("never_rv", resolve_valid, 1'b1);
        check("never_taken", taken, 1'b0);
        check("never_npc", next_pc, 32'h44);
        drive(1'b1, EQ, 1'b1, 3'd1, 32'h80, 32'h20);
        #1;
        check("pre_flush_ready", br_ready, 1'b1);
        tick();
        drive(1'b0, EQ, 1'b0, 3'd0, 32'h0, 32'h0);
        #1;
        check("flush1_flush", flush, 1'b1);
        check("flush1_rv", resolve_valid, 1'b1);
        check("flush1_npc", next_pc, 32'hA0);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_flush", flush, 1'b0);
        check("midrst_rv", resolve_valid, 1'b0);
        check("midrst_fv", flags_valid, 1'b0);
        check("midrst_taken", taken, 1'b0);
        tick();
        rst = 1'b0;
        drive(1'b0, EQ, 1'b0, 3'd0, 32'h0, 32'h0);
        #1;
        check("post_rst_ready_always", br_ready, 1'b1);
        check("post_rst_flush", flush, 1'b0);
        drive(1'b0, EQ, 1'b1, 3'd1, 32'h0, 32'h0);
        #1;
        check("post_rst_ready_eq", br_ready, 1'b0);

        // Random stimulus against the reference model
        do_reset();
        m_flags = EQ; m_fv = 1'b0; m_flush_left = 0;
        m_rv = 1'b0; m_taken = 1'b0; m_npc = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            logic        cv, bv, legal, known, exp_ready, acc, tk;
            logic [1:0]  cmp, eff;
            logic [2:0]  cond;
            logic [31:0] pc, off;
            cv   = ($urandom_range(0, 2) == 0);
            cmp  = 2'($urandom_range(0, 3));
            bv   = ($urandom_range(0, 2) != 0);
            cond = 3'($urandom_range(0, 7));
            pc   = $urandom;
            off  = $urandom;
            drive(cv, cmp, bv, cond, pc, off);
            #1;
            legal     = cv && (cmp != 2'b11);
            eff       = legal ? cmp : m_flags;
            known     = legal || m_fv;
            exp_ready = (m_flush_left == 0) && (cond == 3'd0 || cond == 3'd7 || known);
            check("rnd_ready", br_ready, exp_ready);
            check("rnd_rv", resolve_valid, m_rv);
            check("rnd_taken", taken, m_taken);
            check("rnd_npc", next_pc, m_npc);
            check("rnd_flush", flush, m_flush_left > 0);
            check("rnd_fv", flags_valid, m_fv);
            tick();
            acc  = bv && exp_ready;
            tk   = cond_holds(cond, eff);
            m_rv = acc;
            if (m_flush_left > 0) m_flush_left--;
            if (acc) begin
                m_taken = tk;
                m_npc   = tk ? pc + off : pc + 32'd4;
                if (tk) m_flush_left = F;
            end
            if (legal) begin
                m_flags = cmp;
                m_fv    = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
